// File: rtl/bus_fairness_monitor_if.sv
// bus_fairness_monitor_if: per-channel cmd/rsp handshake bundle observed by the fairness monitor
interface bus_fairness_monitor_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] cmd_valid;
    logic [CHANNELS-1:0] cmd_ready;
    logic [CHANNELS-1:0] cmd_wr;
    logic [CHANNELS-1:0] rsp_ready;

    modport master (output cmd_valid, cmd_ready, cmd_wr, rsp_ready);
    modport slave (input cmd_valid, cmd_ready, cmd_wr, rsp_ready);
endinterface

// File: rtl/bus_fairness_monitor.sv
// bus_fairness_monitor: per-channel command/response wait tracking with a single fairness verdict
module bus_fairness_monitor #(
    parameter int CHANNELS        = 2,
    parameter int MAX_WAIT        = 4,
    parameter int CNT_W           = 3,
    parameter int MAX_OUTSTANDING = 1,
    parameter int OUT_W           = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    bus_fairness_monitor_if.slave     bus,
    output logic                      fair,
    output logic [CHANNELS-1:0]       violation,
    output logic [CHANNELS-1:0]       proto_err,
    output logic [CHANNELS*OUT_W-1:0] outstanding
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    logic [CHANNELS-1:0] atMax;

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        logic [CNT_W-1:0] cmdWait;
        logic [CNT_W-1:0] rspWait;
        logic [OUT_W-1:0] outCnt;
        logic             violFlag;
        logic             errFlag;
        logic             rdAcc;
        logic             rsp;
        logic             overflow;
        logic             underflow;

        assign rdAcc     = bus.cmd_valid[i] & bus.cmd_ready[i] & ~bus.cmd_wr[i];
        assign rsp       = bus.rsp_ready[i];
        assign overflow  = rdAcc & ~rsp & (outCnt == MAX_OUT);
        assign underflow = rsp & ~rdAcc & (outCnt == '0);

        // In-flight reads follow the bus regardless of clear; errors and wait counters are clearable
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cmdWait  <= '0;
                rspWait  <= '0;
                outCnt   <= '0;
                violFlag <= 1'b0;
                errFlag  <= 1'b0;
            end else begin
                outCnt <= (rdAcc & ~rsp & ~overflow) ? outCnt + 1'b1 :
                          (rsp & ~rdAcc & ~underflow) ? outCnt - 1'b1 : outCnt;
                if (clear) begin
                    cmdWait  <= '0;
                    rspWait  <= '0;
                    violFlag <= 1'b0;
                    errFlag  <= 1'b0;
                end else begin
                    cmdWait  <= (bus.cmd_valid[i] & ~bus.cmd_ready[i]) ?
                                ((cmdWait == MAX_CNT) ? MAX_CNT : cmdWait + 1'b1) : '0;
                    rspWait  <= ((outCnt != '0) & ~rsp) ?
                                ((rspWait == MAX_CNT) ? MAX_CNT : rspWait + 1'b1) : '0;
                    violFlag <= violFlag | atMax[i];
                    errFlag  <= errFlag | overflow | underflow;
                end
            end
        end

        assign atMax[i]                       = (cmdWait == MAX_CNT) | (rspWait == MAX_CNT);
        assign violation[i]                   = violFlag;
        assign proto_err[i]                   = errFlag;
        assign outstanding[i*OUT_W +: OUT_W]  = outCnt;
    end

    assign fair = ~|(atMax | proto_err);
endmodule

// File: tb/tb_bus_fairness_monitor.sv
// tb_bus_fairness_monitor: table-driven directed checks plus hand-written multi-cycle sequences
module tb_bus_fairness_monitor;
    logic clock = 1'b0;
    logic reset;
    logic clear;

    bus_fairness_monitor_if #(.CHANNELS(2)) busA ();
    bus_fairness_monitor_if #(.CHANNELS(2)) busB ();

    logic       fairA, fairB;
    logic [1:0] violA, violB, errA, errB;
    logic [1:0] outA;
    logic [3:0] outB;

    bus_fairness_monitor #(.CHANNELS(2), .MAX_WAIT(4), .CNT_W(3), .MAX_OUTSTANDING(1), .OUT_W(1)) dutA (
        .clock(clock), .reset(reset), .clear(clear), .bus(busA),
        .fair(fairA), .violation(violA), .proto_err(errA), .outstanding(outA)
    );

    bus_fairness_monitor #(.CHANNELS(2), .MAX_WAIT(4), .CNT_W(3), .MAX_OUTSTANDING(2), .OUT_W(2)) dutB (
        .clock(clock), .reset(reset), .clear(clear), .bus(busB),
        .fair(fairB), .violation(violB), .proto_err(errB), .outstanding(outB)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       clr;
        logic [1:0] v, r, w, s;
        logic       fair;
        logic [1:0] viol, perr, out;
    } VecRec;

    VecRec vecs[$];
    int checks = 0;
    int failures = 0;

    function automatic void add(logic clr, logic [1:0] v, logic [1:0] r, logic [1:0] w, logic [1:0] s,
                                logic f, logic [1:0] vi, logic [1:0] pe, logic [1:0] o);
        vecs.push_back('{clr, v, r, w, s, f, vi, pe, o});
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic driveA(logic [1:0] v, logic [1:0] r, logic [1:0] w, logic [1:0] s);
        busA.cmd_valid = v;
        busA.cmd_ready = r;
        busA.cmd_wr    = w;
        busA.rsp_ready = s;
    endtask

    task automatic driveB(logic [1:0] v, logic [1:0] r, logic [1:0] w, logic [1:0] s);
        busB.cmd_valid = v;
        busB.cmd_ready = r;
        busB.cmd_wr    = w;
        busB.rsp_ready = s;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // ch0 command stall: fair drops at edge 4, violation at edge 5, then clear
        for (int k = 1; k <= 6; k++)
            add(0, 2'b01, 2'b00, 2'b00, 2'b00, k < 4, (k >= 5) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b01, 2'b00, 2'b00);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00);
        // ch1 short stall resolved by a write accept
        for (int k = 1; k <= 3; k++)
            add(0, 2'b10, 2'b00, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00);
        // ch0 read, response three cycles later, then a write accept
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01);
        add(0, 2'b00, 2'b00, 2'b00, 2'b01, 1, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 2'b01, 2'b00, 1, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00);
        // ch0 response wait saturates at MAX_WAIT
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01);
        for (int k = 1; k <= 4; k++)
            add(0, 2'b00, 2'b00, 2'b00, 2'b00, k < 4, 2'b00, 2'b00, 2'b01);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b01);
        add(0, 2'b00, 2'b00, 2'b00, 2'b01, 1, 2'b01, 2'b00, 2'b00);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00);
        // ch0 response underflow, cleared later
        add(0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 2'b00, 2'b01, 2'b00);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 2'b00);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00);
        // ch0 overflow at MAX_OUTSTANDING=1, accept+rsp at the limit, clear beats an error
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b01);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b00, 2'b01, 2'b01);
        add(0, 2'b01, 2'b01, 2'b00, 2'b01, 0, 2'b00, 2'b01, 2'b01);
        add(1, 2'b00, 2'b00, 2'b00, 2'b01, 1, 2'b00, 2'b00, 2'b00);
        add(1, 2'b00, 2'b00, 2'b00, 2'b01, 1, 2'b00, 2'b00, 2'b00);
        // ch1 independent read, and zero-latency response at count 0 on ch0
        add(0, 2'b10, 2'b10, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b10);
        add(0, 2'b00, 2'b00, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 2'b00, 2'b01, 1, 2'b00, 2'b00, 2'b00);

        reset = 1'b1;
        clear = 1'b0;
        driveA(2'b00, 2'b00, 2'b00, 2'b00);
        driveB(2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) tick();
        reset = 1'b0;
        check("reset_fair", 32'(fairA), 32'd1);
        check("reset_viol", 32'(violA), 32'd0);
        check("reset_perr", 32'(errA), 32'd0);
        check("reset_out", 32'(outA), 32'd0);

        foreach (vecs[n]) begin
            clear = vecs[n].clr;
            driveA(vecs[n].v, vecs[n].r, vecs[n].w, vecs[n].s);
            tick();
            check($sformatf("vec%0d_fair", n), 32'(fairA), 32'(vecs[n].fair));
            check($sformatf("vec%0d_viol", n), 32'(violA), 32'(vecs[n].viol));
            check($sformatf("vec%0d_perr", n), 32'(errA), 32'(vecs[n].perr));
            check($sformatf("vec%0d_out", n), 32'(outA), 32'(vecs[n].out));
        end
        clear = 1'b0;
        driveA(2'b00, 2'b00, 2'b00, 2'b00);

        // MAX_OUTSTANDING=2: three read accepts without responses
        driveB(2'b01, 2'b01, 2'b00, 2'b00);
        tick();
        check("ovf_out1", 32'(outB), 32'd1);
        tick();
        check("ovf_out2", 32'(outB), 32'd2);
        check("ovf_perr2", 32'(errB), 32'd0);
        tick();
        check("ovf_out3", 32'(outB), 32'd2);
        check("ovf_perr3", 32'(errB), 32'd1);
        check("ovf_fair3", 32'(fairB), 32'd0);

        // fresh run: accept+rsp together at count 2 is legal
        driveB(2'b00, 2'b00, 2'b00, 2'b00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        driveB(2'b01, 2'b01, 2'b00, 2'b00);
        repeat (2) tick();
        check("lim_out", 32'(outB), 32'd2);
        driveB(2'b01, 2'b01, 2'b00, 2'b01);
        tick();
        check("lim_both_out", 32'(outB), 32'd2);
        check("lim_both_perr", 32'(errB), 32'd0);
        check("lim_both_fair", 32'(fairB), 32'd1);
        driveB(2'b00, 2'b00, 2'b00, 2'b00);

        // asynchronous reset mid-stall with cmd_wait=3 and one read in flight
        driveA(2'b01, 2'b01, 2'b00, 2'b00);
        tick();
        driveA(2'b01, 2'b00, 2'b00, 2'b00);
        repeat (3) tick();
        check("pre_rst_fair", 32'(fairA), 32'd1);
        check("pre_rst_out", 32'(outA), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_fair", 32'(fairA), 32'd1);
        check("async_rst_viol", 32'(violA), 32'd0);
        check("async_rst_perr", 32'(errA), 32'd0);
        check("async_rst_out", 32'(outA), 32'd0);
        check("async_rst_outB", 32'(outB), 32'd0);
        driveA(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_fairness_monitor.md
# bus_fairness_monitor

Parametrised handshake-fairness monitor for the formal wrappers around our cores. It observes CHANNELS independent cmd/rsp buses (iBus, dBus, …) and counts how long a command waits for `cmd_ready` and how long an accepted read waits for its response. It tracks up to MAX_OUTSTANDING in-flight reads per channel and flags protocol errors. It drives a single `fair` signal that the harness feeds to `restrict`/`assume`, plus sticky per-channel diagnostics. It replaces the ad-hoc per-bus pending counters in the wrappers. It fixes the response-pending counter, which previously counted unconditionally.

## Interface
Parameters:
- CHANNELS, 2: number of monitored buses.
- MAX_WAIT, 4: wait-cycle bound; a counter reaching MAX_WAIT is unfair.
- CNT_W, 3: wait-counter width; must satisfy 2^CNT_W > MAX_WAIT.
- MAX_OUTSTANDING, 1: legal in-flight reads per channel, ≥1.
- OUT_W, 1: outstanding-counter width; must satisfy 2^OUT_W > MAX_OUTSTANDING.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous clear of sticky flags and wait counters.
- cmd_valid  in  CHANNELS  command valid per channel.
- cmd_ready  in  CHANNELS  command ready per channel.
- cmd_wr  in  CHANNELS  1 = write (no response expected).
- rsp_ready  in  CHANNELS  response strobe, one beat per read.
- fair  out  1  1 when no wait counter is at MAX_WAIT and no proto_err is set.
- violation  out  CHANNELS  sticky: a wait counter reached MAX_WAIT.
- proto_err  out  CHANNELS  sticky: response underflow or outstanding overflow.
- outstanding  out  CHANNELS*OUT_W  in-flight read count; channel i occupies bits [i*OUT_W +: OUT_W].

## Operation
Each channel i runs independently, with accept = cmd_valid & cmd_ready and rd_acc = accept & ~cmd_wr.

Command wait counter (cmd_wait):
- cmd_valid & ~cmd_ready: increment, saturating at MAX_WAIT.
- Otherwise: 0.

Outstanding counter:
- rd_acc & ~rsp_ready: +1.
- rsp_ready & ~rd_acc: −1.
- Both rd_acc and rsp_ready: unchanged and legal, even at 0 (zero-latency response) or at MAX_OUTSTANDING.
- Overflow (rd_acc, no rsp_ready, count == MAX_OUTSTANDING): count held, proto_err set.
- Underflow (rsp_ready, no rd_acc, count == 0): count held at 0, proto_err set.

Response wait counter (rsp_wait):
- Current outstanding > 0 and ~rsp_ready: increment, saturating at MAX_WAIT.
- Otherwise: 0.

Sticky flags:
- violation[i] is set on the edge after cmd_wait or rsp_wait equals MAX_WAIT.
- proto_err[i] is set on the edge where the error condition is sampled.
- Both clear only on reset or clear.

fair is combinational from registered state only: ~|(cmd_wait==MAX_WAIT | rsp_wait==MAX_WAIT | proto_err), reduced over all channels. There is no combinational path from any input to fair.

clear zeroes cmd_wait, rsp_wait, violation and proto_err. It does not touch outstanding, because in-flight reads are real. If clear coincides with an error condition, clear wins.

## Timing
- Reset (asynchronous, immediate): all counters, violation, proto_err and outstanding go to 0; fair = 1.
- Counter latency: a counter reaches value k at the k-th rising edge of a continuous stall.
- fair latency: fair drops in the same cycle the counter register reaches MAX_WAIT, i.e. k = MAX_WAIT edges into a stall.
- violation latency: violation rises one edge after fair drops and stays high after the stall ends.
- Recovery: fair returns to 1 in the cycle after the stall resolves, unless proto_err is set.
- Channels are fully independent; activity on one channel never affects another channel's state.
- Saturation: counters hold at MAX_WAIT and never wrap.
- Reset mid-stall or mid-read loses all tracking; the harness re-arms from 0.

## Test plan
MAX_WAIT=4 and CHANNELS=2 unless stated otherwise.
- ch0 cmd_valid=1, cmd_ready=0 for 6 cycles -> cmd_wait 1,2,3,4,4,4; fair=0 from the 4th edge; violation=2'b01 from the 5th edge; ch1 state stays 0.
- ch1 stalled 3 cycles, then cmd_ready=1 -> cmd_wait peaks at 3, then 0; fair stays 1; violation=0.
- ch0 read accepted, rsp_ready 3 cycles later -> outstanding 1 then back to 0; rsp_wait 1,2 then 0; no flags. A write accept leaves outstanding and rsp_wait at 0.
- ch0 rsp_ready with outstanding=0 -> proto_err=2'b01 next edge; outstanding stays 0; fair=0 until clear, which restores fair=1.
- MAX_OUTSTANDING=2, OUT_W=2: three read accepts with no response -> outstanding 1,2,2 and proto_err on the third. A fresh run with accept+rsp in the same cycle at count 2 -> count stays 2, no error.
- reset asserted asynchronously mid-stall with cmd_wait=3 and outstanding=1 -> all outputs 0 and fair=1 before the next clock edge.
